// File: rtl/issue_pkg.sv
// Shared types and default widths for the issue queue and its age selector.
package issue_pkg;

  localparam int IQ_TAG_W = 6;
  localparam int IQ_OP_W  = 8;

  typedef struct packed {
    logic                valid;
    logic [IQ_OP_W-1:0]  op;
    logic [IQ_TAG_W-1:0] dst;
    logic [IQ_TAG_W-1:0] src1;
    logic [IQ_TAG_W-1:0] src2;
    logic                rdy1;
    logic                rdy2;
  } iq_entry_t;

endpackage

// File: rtl/iq_age_select.sv
// N-entry age matrix with oldest-eligible grant.
// age_q[i][j] = 1 means entry i is older than entry j. Bits belonging to
// invalid entries may be stale; the eligible mask hides them from select.
module iq_age_select #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DEPTH-1:0] alloc,     // one-hot entry written this edge, or zero
  input  logic [DEPTH-1:0] valid,     // entries still valid after this edge's issue
  input  logic [DEPTH-1:0] eligible,
  output logic [DEPTH-1:0] grant
);

  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];

  // A newly allocated entry is younger than every entry that survives the edge.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) age_d[i] = age_q[i];
    for (int k = 0; k < DEPTH; k++) begin
      if (alloc[k]) begin
        age_d[k] = '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != k) age_d[j][k] = valid[j];
        end
      end
    end
  end

  // Age matrix register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end
  end

  // Grant the eligible entry that is older than every other eligible entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = eligible[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && eligible[j] && !age_q[i][j]) grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue: DEPTH entries, tag wakeup, oldest-ready issue.
// Optional statistics ports (occupancy, full_stalls) are built when the
// macro ISSUE_QUEUE_STATS_EN is defined; queue behaviour is unchanged.
module issue_queue
  import issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = IQ_TAG_W,
  parameter int OP_W  = IQ_OP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [TAG_W-1:0] disp_dst,
  input  logic [TAG_W-1:0] disp_src1,
  input  logic [TAG_W-1:0] disp_src2,
  input  logic             disp_rdy1,
  input  logic             disp_rdy2,
  input  logic             wake_valid,
  input  logic [TAG_W-1:0] wake_tag,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [OP_W-1:0]  iss_op,
  output logic [TAG_W-1:0] iss_dst
`ifdef ISSUE_QUEUE_STATS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [31:0]                full_stalls
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  iq_entry_t        entry_q [DEPTH];
  iq_entry_t        entry_d [DEPTH];
  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] eligible;
  logic [DEPTH-1:0] grant;
  logic [DEPTH-1:0] alloc;
  logic [DEPTH-1:0] iss_clr;
  logic [CNT_W-1:0] occ;
  logic             free_seen;
  logic             disp_fire;
  logic             iss_fire;
  logic             cap_rdy1;
  logic             cap_rdy2;

  // Per-entry valid and eligibility from registered state.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entry_q[i].valid;
      eligible[i]  = entry_q[i].valid && entry_q[i].rdy1 && entry_q[i].rdy2;
    end
  end

  // Occupancy count; an entry freed this cycle still counts until the edge.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + CNT_W'(valid_vec[i]);
  end

  assign disp_ready = (occ < CNT_W'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready;
  assign iss_valid  = |grant;
  assign iss_fire   = iss_valid && iss_ready;
  assign iss_clr    = grant & {DEPTH{iss_fire}};

  // Issue payload mux; grant is one-hot or zero, so OR-reduction is exact.
  always_comb begin
    iss_op  = '0;
    iss_dst = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        iss_op  = iss_op | entry_q[i].op;
        iss_dst = iss_dst | entry_q[i].dst;
      end
    end
  end

  // Lowest-index free entry; suppressed when no dispatch fires or on flush.
  always_comb begin
    alloc     = '0;
    free_seen = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_vec[i] && !free_seen) begin
        alloc[i]  = 1'b1;
        free_seen = 1'b1;
      end
    end
    if (!disp_fire || flush) alloc = '0;
  end

  // A broadcast in the dispatch cycle is folded into the captured ready bits.
  assign cap_rdy1 = disp_rdy1 || (wake_valid && (wake_tag == disp_src1));
  assign cap_rdy2 = disp_rdy2 || (wake_valid && (wake_tag == disp_src2));

  // Entry update: wakeup, issue release, allocation, then flush override.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (entry_q[i].valid && wake_valid && !iss_clr[i]) begin
        if (entry_q[i].src1 == wake_tag) entry_d[i].rdy1 = 1'b1;
        if (entry_q[i].src2 == wake_tag) entry_d[i].rdy2 = 1'b1;
      end
      if (iss_clr[i]) entry_d[i].valid = 1'b0;
      if (alloc[i]) begin
        entry_d[i].valid = 1'b1;
        entry_d[i].op    = disp_op;
        entry_d[i].dst   = disp_dst;
        entry_d[i].src1  = disp_src1;
        entry_d[i].src2  = disp_src2;
        entry_d[i].rdy1  = cap_rdy1;
        entry_d[i].rdy2  = cap_rdy2;
      end
      if (flush) entry_d[i].valid = 1'b0;
    end
  end

  // Entry array register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

  iq_age_select #(
    .DEPTH (DEPTH)
  ) u_age_select (
    .clk      (clk),
    .reset    (reset),
    .alloc    (alloc),
    .valid    (valid_vec & ~iss_clr),
    .eligible (eligible),
    .grant    (grant)
  );

`ifdef ISSUE_QUEUE_STATS_EN
  logic [31:0] full_stalls_q;
  logic [31:0] full_stalls_d;

  // Saturating count of cycles a dispatch was refused; flush leaves it alone.
  always_comb begin
    full_stalls_d = full_stalls_q;
    if (disp_valid && !disp_ready && (full_stalls_q != 32'hFFFF_FFFF))
      full_stalls_d = full_stalls_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) full_stalls_q <= '0;
    else        full_stalls_q <= full_stalls_d;
  end

  assign occupancy   = occ;
  assign full_stalls = full_stalls_q;
`endif

endmodule
